mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_array.sv | 27 ++
 rtl/mem_responder.sv | 83 ++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-port memory responder: FSM encoding, default
// geometry/latency and the latched request record.
package mem_responder_pkg;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        read;
        logic        write;
    } req_t;

    // An access is rejected when misaligned, beyond storage, or both read and write.
    function automatic logic access_error(input req_t req, input int unsigned depth_words);
        return (req.adr[1:0] != 2'b00)
            || ({2'b00, req.adr[31:2]} >= depth_words)
            || (req.read && req.write);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned ADR_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADR_W-1:0] adr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset; its contents must survive a reset and a
    // reset network on every word would only cost area.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[adr] <= wdata;
        end
    end

    assign rdata = (32'(adr) < DEPTH_WORDS) ? mem[adr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder for the processor data port: latches one request,
// inserts WAIT_CYCLES wait states, then completes with a one-cycle mem_ready.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int unsigned ADR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]  state;
    logic [3:0]  cnt;
    req_t        req_q;
    logic        done;
    logic        err;
    logic        we;
    logic [31:0] array_rdata;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_q <= '{adr: mem_adr, wdata: mem_wdata,
                                   read: mem_read, write: mem_write};
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    // Count saturates at zero; the move to DONE coincides with reaching it.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    if (cnt <= 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign done = (state == DONE);
    assign err  = access_error(req_q, DEPTH_WORDS);

    // Commit happens on the edge that ends DONE; a reset in DONE drops we first.
    assign we = done && req_q.write && !err;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADR_W      (ADR_W)
    ) u_mem_array (
        .clk  (clk),
        .we   (we),
        .adr  (req_q.adr[ADR_W+1:2]),
        .wdata(req_q.wdata),
        .rdata(array_rdata)
    );

    assign mem_ready = done;
    assign mem_err   = done && err;
    assign mem_rdata = (done && req_q.read && !err) ? array_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a 2-wait-state and a 0-wait-state instance
// driven with directed and random accesses against a word-array reference model.
module tb_mem_responder;

    localparam int unsigned W_A    = 2;
    localparam int unsigned W_Z    = 0;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned NWORDS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] a_adr, a_wdata, a_rdata;
    logic        a_read, a_write, a_ready, a_err;
    logic [31:0] z_adr, z_wdata, z_rdata;
    logic        z_read, z_write, z_ready, z_err;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_z[$];
    logic [31:0] model_a [NWORDS];
    logic [31:0] model_z [NWORDS];

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) dut_a (
        .clk(clk), .rst(rst), .mem_adr(a_adr), .mem_wdata(a_wdata),
        .mem_read(a_read), .mem_write(a_write), .mem_rdata(a_rdata),
        .mem_ready(a_ready), .mem_err(a_err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_Z)) dut_z (
        .clk(clk), .rst(rst), .mem_adr(z_adr), .mem_wdata(z_wdata),
        .mem_read(z_read), .mem_write(z_write), .mem_rdata(z_rdata),
        .mem_ready(z_ready), .mem_err(z_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour: error rules, then read/write on a plain word array.
    function automatic exp_t model_access(input bit z, input logic rd, input logic wr,
                                          input logic [31:0] adr, input logic [31:0] wd,
                                          input int done_cyc);
        exp_t        e;
        int unsigned word = adr >> 2;
        e.err   = ((adr % 4) != 0) || (word >= DEPTH) || (rd && wr);
        e.rdata = '0;
        e.cyc   = done_cyc;
        if (!e.err) begin
            if (rd) e.rdata = z ? model_z[word] : model_a[word];
            if (wr) begin
                if (z) model_z[word] = wd;
                else   model_a[word] = wd;
            end
        end
        return e;
    endfunction

    task automatic drive(input bit z, input logic rd, input logic wr,
                         input logic [31:0] adr, input logic [31:0] wd);
        if (z) begin
            z_read = rd; z_write = wr; z_adr = adr; z_wdata = wd;
        end else begin
            a_read = rd; a_write = wr; a_adr = adr; a_wdata = wd;
        end
    endtask

    task automatic push_expect(input bit z, input logic rd, input logic wr,
                               input logic [31:0] adr, input logic [31:0] wd);
        int   lat = z ? int'(W_Z) + 1 : int'(W_A) + 1;
        exp_t e   = model_access(z, rd, wr, adr, wd, cyc + lat);
        if (z) q_z.push_back(e);
        else   q_a.push_back(e);
    endtask

    task automatic issue(input bit z, input logic rd, input logic wr,
                         input logic [31:0] adr, input logic [31:0] wd);
        drive(z, rd, wr, adr, wd);
        push_expect(z, rd, wr, adr, wd);
    endtask

    task automatic wait_ready(input bit z);
        bit got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((z ? z_ready : a_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(z ? "z_ready_seen" : "a_ready_seen", 32'(got), 32'd1);
    endtask

    task automatic complete(input bit z);
        wait_ready(z);
        drive(z, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_access(input bit z, input logic rd, input logic wr,
                             input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        issue(z, rd, wr, adr, wd);
        complete(z);
    endtask

    task automatic rand_access(input bit z);
        int unsigned r = $urandom_range(0, 9);
        int unsigned k = $urandom_range(0, 9);
        int unsigned w = $urandom_range(0, NWORDS - 1);
        logic [31:0] adr;
        logic        rd, wr;
        if (r == 0)      adr = (w << 2) + $urandom_range(1, 3);
        else if (r == 1) adr = (DEPTH + $urandom_range(0, 4095)) << 2;
        else             adr = w << 2;
        rd = (k == 0) || (k >= 5);
        wr = (k <= 4);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_access(z, rd, wr, adr, $urandom);
    endtask

    // Monitors: pop on every completion, otherwise outputs must be idle zeros.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("a_reset_ready", 32'(a_ready), '0);
            check("a_reset_err", 32'(a_err), '0);
            check("a_reset_rdata", a_rdata, '0);
        end else if (a_ready) begin
            if (q_a.size() == 0) begin
                check("a_spurious_ready", 32'(q_a.size()), 32'd1);
            end else begin
                e = q_a.pop_front();
                check("a_rdata", a_rdata, e.rdata);
                check("a_err", 32'(a_err), 32'(e.err));
                check("a_ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("a_idle_rdata", a_rdata, '0);
            check("a_idle_err", 32'(a_err), '0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("z_reset_ready", 32'(z_ready), '0);
            check("z_reset_rdata", z_rdata, '0);
        end else if (z_ready) begin
            if (q_z.size() == 0) begin
                check("z_spurious_ready", 32'(q_z.size()), 32'd1);
            end else begin
                e = q_z.pop_front();
                check("z_rdata", z_rdata, e.rdata);
                check("z_err", 32'(z_err), 32'(e.err));
                check("z_ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("z_idle_rdata", z_rdata, '0);
            check("z_idle_err", 32'(z_err), '0);
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #1 rst = 1'b0;
        #1;
        check("por_ready", 32'(a_ready), '0);
        check("por_rdata", a_rdata, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Give every modelled word a known value.
        for (int i = 0; i < int'(NWORDS); i++) begin
            do_access(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom);
            do_access(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom);
        end

        do_access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_access(1'b0, 1'b1, 1'b0, 32'h10, '0);

        do_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678);
        do_access(1'b1, 1'b1, 1'b0, 32'h0, '0);

        do_access(1'b0, 1'b1, 1'b0, 32'h6, '0);
        do_access(1'b0, 1'b1, 1'b0, 32'h1000, '0);
        do_access(1'b0, 1'b0, 1'b1, 32'h1000, 32'h55AA55AA);
        do_access(1'b0, 1'b1, 1'b0, 32'h0, '0);
        do_access(1'b0, 1'b1, 1'b0, 32'h4, '0);

        do_access(1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
        do_access(1'b0, 1'b1, 1'b0, 32'h20, '0);

        // Write aborted by reset while waiting; read issued in the first idle cycle after.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ready", 32'(a_ready), '0);
        check("abort_err", 32'(a_err), '0);
        check("abort_rdata", a_rdata, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 1'b1, 1'b0, 32'h40, '0);
        complete(1'b0);

        // Address change during WAIT is ignored; holding past DONE starts a second access.
        @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 32'h8, '0);
        @(negedge clk);
        a_adr = 32'hC;
        wait_ready(1'b0);
        @(negedge clk);
        push_expect(1'b0, 1'b1, 1'b0, 32'hC, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        complete(1'b0);

        repeat (80) rand_access(1'b0);
        repeat (20) rand_access(1'b1);

        repeat (5) @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), '0);
        check("z_queue_drained", 32'(q_z.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
